// File: rtl/me_pkg.sv
// Shared motion-estimation package: default geometry used by the SAD engine
// and the address generator, plus width helpers.
package me_pkg;

  localparam int DEF_PIX_W  = 8;
  localparam int DEF_COLS   = 4;
  localparam int DEF_ROWS   = 4;
  localparam int DEF_ADDR_W = 8;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Width of one row sum once COLS pixel differences are added.
  function automatic int row_sum_w(input int pix_w, input int cols);
    return pix_w + clog2(cols);
  endfunction

  // Width of a full-block SAD (COLS*ROWS pixel differences).
  function automatic int sad_w(input int pix_w, input int cols, input int rows);
    return pix_w + clog2(cols * rows);
  endfunction

endpackage

// File: rtl/sad_block_engine_if.sv
// Beat/result bus of the SAD engine. The master modport is the side that
// feeds row beats (address generator); the slave modport is the engine.
interface sad_block_engine_if import me_pkg::*; #(
  parameter int PIX_W  = DEF_PIX_W,
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int ADDR_W = DEF_ADDR_W
);
  localparam int SAD_W = sad_w(PIX_W, COLS, ROWS);

  logic                  search_start;
  logic                  in_valid;
  logic                  in_first;
  logic [COLS*PIX_W-1:0] cur_row;
  logic [COLS*PIX_W-1:0] can_row;
  logic [ADDR_W-1:0]     can_addr;

  logic                  sad_valid;
  logic [SAD_W-1:0]      sad;
  logic [ADDR_W-1:0]     sad_addr;
  logic                  best_valid;
  logic [SAD_W-1:0]      best_sad;
  logic [ADDR_W-1:0]     best_addr;

  modport master (
    output search_start, in_valid, in_first, cur_row, can_row, can_addr,
    input  sad_valid, sad, sad_addr, best_valid, best_sad, best_addr
  );

  modport slave (
    input  search_start, in_valid, in_first, cur_row, can_row, can_addr,
    output sad_valid, sad, sad_addr, best_valid, best_sad, best_addr
  );
endinterface

// File: rtl/sad_block_engine_adder_tree.sv
// Registered binary adder tree: N inputs of IN_W bits reduced to one sum,
// one register level per halving, so latency is clog2(N). A valid bit
// travels alongside and can be flushed without touching the data path.
module sad_adder_tree import me_pkg::*; #(
  parameter  int N     = DEF_COLS,
  parameter  int IN_W  = DEF_PIX_W,
  localparam int LAT   = clog2(N),
  localparam int OUT_W = IN_W + LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [N*IN_W-1:0] i_data,
  output logic              o_valid,
  output logic [OUT_W-1:0]  o_sum
);

  logic [OUT_W-1:0] w_leaf [N];
  logic [LAT-1:0]   r_vld;

  for (genvar k = 0; k < N; k++) begin : g_leaf
    assign w_leaf[k] = OUT_W'(i_data[k*IN_W +: IN_W]);
  end

  for (genvar l = 1; l <= LAT; l++) begin : g_lvl
    logic [OUT_W-1:0] r_node [N >> l];
    if (l == 1) begin : g_from_leaf
      // First level pairs up the zero-extended leaf inputs.
      always_ff @(posedge clk) begin
        for (int k = 0; k < (N >> l); k++)
          r_node[k] <= w_leaf[2*k] + w_leaf[2*k+1];
      end
    end else begin : g_from_prev
      // Later levels pair up the registered sums of the level below.
      always_ff @(posedge clk) begin
        for (int k = 0; k < (N >> l); k++)
          r_node[k] <= g_lvl[l-1].r_node[2*k] + g_lvl[l-1].r_node[2*k+1];
      end
    end
  end

  // Valid shift register tracks which level holds a live row; flush drops all.
  always_ff @(posedge clk) begin
    if (rst || i_flush) r_vld <= '0;
    else                r_vld <= (r_vld << 1) | LAT'(i_valid);
  end

  assign o_valid = r_vld[LAT-1];
  assign o_sum   = g_lvl[LAT].r_node[0];

endmodule

// File: rtl/sad_block_engine.sv
// Pipelined SAD engine: per-pixel abs diff, adder tree per row, row
// accumulator per candidate, and a running minimum over the current search.
module sad_block_engine import me_pkg::*; #(
  parameter int PIX_W  = DEF_PIX_W,
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic clk,
  input logic rst,
  sad_block_engine_if.slave bus
);

  localparam int TREE_LAT = clog2(COLS);
  localparam int ROW_W    = row_sum_w(PIX_W, COLS);
  localparam int SAD_W    = sad_w(PIX_W, COLS, ROWS);
  localparam int CNT_W    = clog2(ROWS + 1);

  logic                  w_flush;
  logic [COLS*PIX_W-1:0] w_diff;
  logic                  r_aValid, r_aFirst;
  logic [COLS*PIX_W-1:0] r_aDiff;
  logic [ADDR_W-1:0]     r_aAddr;
  logic                  r_tagFirst [TREE_LAT];
  logic [ADDR_W-1:0]     r_tagAddr  [TREE_LAT];
  logic                  w_rowValid, w_rowFirst;
  logic [ROW_W-1:0]      w_rowSum;
  logic [ADDR_W-1:0]     w_rowAddr;
  logic                  w_take, w_last;
  logic [CNT_W-1:0]      w_cntNext, r_cnt;
  logic [SAD_W-1:0]      w_accNext, r_acc;
  logic [ADDR_W-1:0]     r_accAddr;
  logic                  r_done;
  logic                  r_sadValid, r_bestValid;
  logic [SAD_W-1:0]      r_sad, r_bestSad;
  logic [ADDR_W-1:0]     r_sadAddr, r_bestAddr;

  assign w_flush = rst || bus.search_start;

  for (genvar k = 0; k < COLS; k++) begin : g_abs
    logic [PIX_W-1:0] w_cur, w_can;
    assign w_cur = bus.cur_row[k*PIX_W +: PIX_W];
    assign w_can = bus.can_row[k*PIX_W +: PIX_W];
    assign w_diff[k*PIX_W +: PIX_W] = (w_cur > w_can) ? (w_cur - w_can) : (w_can - w_cur);
  end

  // Stage A: register the differences; a beat arriving with search_start still counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aValid <= 1'b0;
      r_aFirst <= 1'b0;
    end else begin
      r_aValid <= bus.in_valid;
      r_aFirst <= bus.in_valid && bus.in_first;
    end
    r_aDiff <= w_diff;
    if (bus.in_valid && bus.in_first) r_aAddr <= bus.can_addr;
  end

  sad_adder_tree #(.N(COLS), .IN_W(PIX_W)) u_tree (
    .clk     (clk),
    .rst     (rst),
    .i_flush (bus.search_start),
    .i_valid (r_aValid),
    .i_data  (r_aDiff),
    .o_valid (w_rowValid),
    .o_sum   (w_rowSum)
  );

  // Side registers keep first flag and address aligned with the tree output.
  always_ff @(posedge clk) begin
    r_tagFirst[0] <= r_aFirst;
    r_tagAddr[0]  <= r_aAddr;
    for (int i = 1; i < TREE_LAT; i++) begin
      r_tagFirst[i] <= r_tagFirst[i-1];
      r_tagAddr[i]  <= r_tagAddr[i-1];
    end
  end

  assign w_rowFirst = r_tagFirst[TREE_LAT-1];
  assign w_rowAddr  = r_tagAddr[TREE_LAT-1];

  // Decide whether a row joins a candidate: first rows restart, orphans are dropped.
  always_comb begin
    w_take    = 1'b0;
    w_cntNext = r_cnt;
    w_accNext = r_acc;
    if (w_rowValid) begin
      if (w_rowFirst) begin
        w_take    = 1'b1;
        w_cntNext = CNT_W'(1);
        w_accNext = SAD_W'(w_rowSum);
      end else if (r_cnt != '0) begin
        w_take    = 1'b1;
        w_cntNext = r_cnt + CNT_W'(1);
        w_accNext = r_acc + SAD_W'(w_rowSum);
      end
    end
    w_last = w_take && (w_cntNext == CNT_W'(ROWS));
  end

  // Stage C: accumulate rows; count returns to 0 so stray non-first rows are ignored.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_take) begin
        r_acc <= w_accNext;
        r_cnt <= w_last ? '0 : w_cntNext;
      end
      if (w_take && w_rowFirst) r_accAddr <= w_rowAddr;
    end
  end

  // Result register: pulses once per completed candidate, holds value between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sadValid <= 1'b0;
      r_sad      <= '0;
      r_sadAddr  <= '0;
    end else if (bus.search_start) begin
      r_sadValid <= 1'b0;
    end else begin
      r_sadValid <= r_done;
      if (r_done) begin
        r_sad     <= r_acc;
        r_sadAddr <= r_accAddr;
      end
    end
  end

  // Best tracker: strict less-than so a tie keeps the earlier address.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_bestValid <= 1'b0;
      r_bestSad   <= '1;
      r_bestAddr  <= '0;
    end else if (r_sadValid && (!r_bestValid || (r_sad < r_bestSad))) begin
      r_bestValid <= 1'b1;
      r_bestSad   <= r_sad;
      r_bestAddr  <= r_sadAddr;
    end
  end

  assign bus.sad_valid  = r_sadValid;
  assign bus.sad        = r_sad;
  assign bus.sad_addr   = r_sadAddr;
  assign bus.best_valid = r_bestValid;
  assign bus.best_sad   = r_bestSad;
  assign bus.best_addr  = r_bestAddr;

endmodule

// File: tb/tb_sad_block_engine.sv
// Bench for sad_block_engine: default geometry driven from a vector table and
// directed corner sequences, plus a COLS=8/ROWS=2/PIX_W=10 instance checked
// against a software SAD model with a mid-stream reset.
module tb_sad_block_engine;

  logic clk;
  logic rst;
  logic rst2;
  int   cyc = 0;
  int   nChecks = 0;
  int   nErrors = 0;

  sad_block_engine_if #(.PIX_W(8), .COLS(4), .ROWS(4), .ADDR_W(8)) b1 ();
  sad_block_engine_if #(.PIX_W(10), .COLS(8), .ROWS(2), .ADDR_W(8)) b2 ();

  sad_block_engine #(.PIX_W(8), .COLS(4), .ROWS(4), .ADDR_W(8)) dut1 (
    .clk (clk), .rst (rst), .bus (b1.slave));
  sad_block_engine #(.PIX_W(10), .COLS(8), .ROWS(2), .ADDR_W(8)) dut2 (
    .clk (clk), .rst (rst2), .bus (b2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitors: record cycle, SAD and tag of every sad_valid pulse.
  int m1Cyc[$], m1Sad[$], m1Addr[$];
  int m2Cyc[$], m2Sad[$], m2Addr[$];
  always @(negedge clk) begin
    if (b1.sad_valid) begin
      m1Cyc.push_back(cyc); m1Sad.push_back(int'(b1.sad)); m1Addr.push_back(int'(b1.sad_addr));
    end
    if (b2.sad_valid) begin
      m2Cyc.push_back(cyc); m2Sad.push_back(int'(b2.sad)); m2Addr.push_back(int'(b2.sad_addr));
    end
  end

  typedef struct packed {
    logic [127:0] cur;
    logic [127:0] can;
    logic [7:0]   tag;
    logic [11:0]  expSad;
  } vec_t;
  vec_t vecs [6];

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkPulse1(input string name, input int expCyc, input int expSad, input int expAddr);
    if (m1Cyc.size() == 0) begin
      nChecks++; nErrors++;
      $display("[TB] FAIL %s: got no pulse, expected sad %0d at cycle %0d", name, expSad, expCyc);
    end else begin
      checkOutput({name, "_cycle"}, m1Cyc.pop_front(), expCyc);
      checkOutput({name, "_sad"},   m1Sad.pop_front(), expSad);
      checkOutput({name, "_addr"},  m1Addr.pop_front(), expAddr);
    end
  endtask

  task automatic checkPulse2(input string name, input int expCyc, input int expSad, input int expAddr);
    if (m2Cyc.size() == 0) begin
      nChecks++; nErrors++;
      $display("[TB] FAIL %s: got no pulse, expected sad %0d at cycle %0d", name, expSad, expCyc);
    end else begin
      checkOutput({name, "_cycle"}, m2Cyc.pop_front(), expCyc);
      checkOutput({name, "_sad"},   m2Sad.pop_front(), expSad);
      checkOutput({name, "_addr"},  m2Addr.pop_front(), expAddr);
    end
  endtask

  task automatic checkBest1(input string name, input int bv, input int bs, input int ba);
    checkOutput({name, "_best_valid"}, int'(b1.best_valid), bv);
    checkOutput({name, "_best_sad"},   int'(b1.best_sad), bs);
    checkOutput({name, "_best_addr"},  int'(b1.best_addr), ba);
  endtask

  task automatic clearMon1();
    m1Cyc.delete(); m1Sad.delete(); m1Addr.delete();
  endtask

  // One beat on the default-geometry DUT; accEdge returns the accepting cycle.
  task automatic applyStimulus(input logic [31:0] cur, input logic [31:0] can, input logic valid,
                               input logic first, input logic [7:0] addr, input logic ss,
                               output int accEdge);
    b1.cur_row = cur; b1.can_row = can; b1.in_valid = valid;
    b1.in_first = first; b1.can_addr = addr; b1.search_start = ss;
    @(posedge clk); #1;
    accEdge = cyc;
    b1.in_valid = 1'b0; b1.in_first = 1'b0; b1.search_start = 1'b0;
  endtask

  task automatic applyBeat2(input logic [79:0] cur, input logic [79:0] can, input logic first,
                            input logic [7:0] addr, output int accEdge);
    b2.cur_row = cur; b2.can_row = can; b2.in_valid = 1'b1;
    b2.in_first = first; b2.can_addr = addr; b2.search_start = 1'b0;
    @(posedge clk); #1;
    accEdge = cyc;
    b2.in_valid = 1'b0; b2.in_first = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Full 4-row candidate with the same row pattern on every row.
  task automatic uniformCand(input logic [31:0] cur, input logic [31:0] can, input logic [7:0] tag,
                             output int lastEdge);
    for (int r = 0; r < 4; r++) applyStimulus(cur, can, 1'b1, r == 0, tag, 1'b0, lastEdge);
  endtask

  // Random 2-row candidate for the wide instance; model SAD computed here.
  task automatic randCand2(input logic [7:0] tag, output int lastEdge, output int sadv);
    logic [79:0] cur, can;
    int a, b;
    sadv = 0;
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 8; p++) begin
        a = int'($urandom_range(0, 1023));
        b = int'($urandom_range(0, 1023));
        cur[p*10 +: 10] = 10'(a);
        can[p*10 +: 10] = 10'(b);
        sadv += (a > b) ? (a - b) : (b - a);
      end
      applyBeat2(cur, can, r == 0, tag, lastEdge);
      if (r == 0 && $urandom_range(0, 1) == 1) idle(1);
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lastE, e;
    int lastArr[3];
    int bestS, bestA, sadv;
    int expC[$], expS[$], expA[$];
    logic bestV;
    logic [31:0] btbCan[3][4];
    logic [7:0]  btbTag[3];

    vecs[0] = '{cur: {4{32'h0A0A0A0A}}, can: {4{32'h0D0D0D0D}}, tag: 8'h5A, expSad: 12'd48};
    vecs[1] = '{cur: {4{32'h00000000}}, can: {4{32'hFFFFFFFF}}, tag: 8'h01, expSad: 12'd4080};
    vecs[2] = '{cur: {4{32'hFFFFFFFF}}, can: {4{32'h00000000}}, tag: 8'h02, expSad: 12'd4080};
    vecs[3] = '{cur: {4{32'h01020304}}, can: {4{32'h04030201}}, tag: 8'h77, expSad: 12'd32};
    vecs[4] = '{cur: {32'h12345678, 32'h9ABCDEF0, 32'h0, 32'hFFFFFFFF},
                can: {32'h12345678, 32'h9ABCDEF0, 32'h0, 32'hFFFFFFFF}, tag: 8'h0F, expSad: 12'd0};
    vecs[5] = '{cur: {32'h10101010, 32'h00000000, 32'h80808080, 32'hFF00FF00},
                can: {32'h00000000, 32'h01010101, 32'h7F7F7F7F, 32'h00FF00FF}, tag: 8'hC3, expSad: 12'd1092};

    rst = 1'b1; rst2 = 1'b1;
    b1.search_start = 1'b0; b1.in_valid = 1'b0; b1.in_first = 1'b0;
    b1.cur_row = '0; b1.can_row = '0; b1.can_addr = '0;
    b2.search_start = 1'b0; b2.in_valid = 1'b0; b2.in_first = 1'b0;
    b2.cur_row = '0; b2.can_row = '0; b2.can_addr = '0;
    idle(3);
    checkOutput("reset_sad_valid", int'(b1.sad_valid), 0);
    checkOutput("reset_sad", int'(b1.sad), 0);
    checkOutput("reset_sad_addr", int'(b1.sad_addr), 0);
    checkBest1("reset", 0, 4095, 0);
    rst = 1'b0; rst2 = 1'b0;
    idle(2);

    // Table: each vector opens a fresh search on its first row.
    for (int v = 0; v < 6; v++) begin
      clearMon1();
      for (int r = 0; r < 4; r++)
        applyStimulus(vecs[v].cur[(3-r)*32 +: 32], vecs[v].can[(3-r)*32 +: 32], 1'b1,
                      r == 0, vecs[v].tag, r == 0, lastE);
      idle(8);
      checkOutput($sformatf("vec%0d_pulses", v), m1Cyc.size(), 1);
      checkPulse1($sformatf("vec%0d", v), lastE + 4, int'(vecs[v].expSad), int'(vecs[v].tag));
      checkBest1($sformatf("vec%0d", v), 1, int'(vecs[v].expSad), int'(vecs[v].tag));
    end

    // Back-to-back candidates, SADs 100/60/60: tie must keep 0x35.
    btbTag = '{8'h21, 8'h35, 8'h47};
    btbCan[0] = '{32'h19191919, 32'h0, 32'h0, 32'h0};
    btbCan[1] = '{32'h0F0F0F0F, 32'h0, 32'h0, 32'h0};
    btbCan[2] = '{32'h0, 32'h0F0F0F0F, 32'h0, 32'h0};
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 8'h0, 1'b1, e);
    clearMon1();
    for (int i = 0; i < 3; i++)
      for (int r = 0; r < 4; r++)
        applyStimulus(32'h0, btbCan[i][r], 1'b1, r == 0, btbTag[i], 1'b0, lastArr[i]);
    idle(10);
    checkOutput("btb_pulses", m1Cyc.size(), 3);
    checkPulse1("btb0", lastArr[0] + 4, 100, 'h21);
    checkPulse1("btb1", lastArr[0] + 8, 60, 'h35);
    checkPulse1("btb2", lastArr[0] + 12, 60, 'h47);
    checkBest1("btb", 1, 60, 'h35);

    // Orphan row, abandoned 2-row candidate, then a gapped candidate.
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 8'h0, 1'b1, e);
    clearMon1();
    applyStimulus(32'h0, 32'hFFFFFFFF, 1'b1, 1'b0, 8'h99, 1'b0, e);
    applyStimulus(32'h0, 32'hFFFFFFFF, 1'b1, 1'b1, 8'h10, 1'b0, e);
    applyStimulus(32'h0, 32'hFFFFFFFF, 1'b1, 1'b0, 8'h10, 1'b0, e);
    for (int r = 0; r < 4; r++) begin
      applyStimulus(32'h0A0A0A0A, 32'h0D0D0D0D, 1'b1, r == 0, 8'h11, 1'b0, lastE);
      if (r < 3) idle(3);
    end
    idle(10);
    checkOutput("abandon_pulses", m1Cyc.size(), 1);
    checkPulse1("abandon", lastE + 4, 48, 'h11);
    checkBest1("abandon", 1, 48, 'h11);

    // search_start one cycle before a pulse drops it and clears best.
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 8'h0, 1'b1, e);
    clearMon1();
    uniformCand(32'h0A0A0A0A, 32'h0D0D0D0D, 8'h40, lastE);
    idle(8);
    checkPulse1("pre_flush", lastE + 4, 48, 'h40);
    uniformCand(32'h0A0A0A0A, 32'h0D0D0D0D, 8'h66, lastE);
    idle(2);
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 8'h0, 1'b1, e);
    idle(8);
    checkOutput("flush_pulses", m1Cyc.size(), 0);
    checkBest1("flush", 0, 4095, 0);
    applyStimulus(32'h0, 32'h01020400, 1'b1, 1'b1, 8'h70, 1'b0, e);
    for (int r = 1; r < 4; r++) applyStimulus(32'h0, 32'h0, 1'b1, 1'b0, 8'h70, 1'b0, lastE);
    idle(8);
    checkPulse1("post_flush", lastE + 4, 7, 'h70);
    checkBest1("post_flush", 1, 7, 'h70);

    // Wide instance: random candidates against the model, latency 5.
    bestV = 1'b0; bestS = 0; bestA = 0;
    for (int i = 0; i < 4; i++) begin
      randCand2(8'(8'hA0 + i), lastE, sadv);
      expC.push_back(lastE + 5); expS.push_back(sadv); expA.push_back(8'hA0 + i);
      if (!bestV || sadv < bestS) begin bestV = 1'b1; bestS = sadv; bestA = 8'hA0 + i; end
    end
    idle(10);
    checkOutput("wide_pulses", m2Cyc.size(), 4);
    while (expC.size() > 0)
      checkPulse2("wide", expC.pop_front(), expS.pop_front(), expA.pop_front());
    checkOutput("wide_best_sad", int'(b2.best_sad), bestS);
    checkOutput("wide_best_addr", int'(b2.best_addr), bestA);

    randCand2(8'hB0, lastE, sadv);
    idle(1);
    rst2 = 1'b1;
    idle(1);
    rst2 = 1'b0;
    idle(8);
    checkOutput("wide_rst_pulses", m2Cyc.size(), 0);
    checkOutput("wide_rst_sad", int'(b2.sad), 0);
    checkOutput("wide_rst_best_valid", int'(b2.best_valid), 0);
    checkOutput("wide_rst_best_sad", int'(b2.best_sad), 16383);

    bestV = 1'b0;
    for (int i = 0; i < 2; i++) begin
      randCand2(8'(8'hC0 + i), lastE, sadv);
      expC.push_back(lastE + 5); expS.push_back(sadv); expA.push_back(8'hC0 + i);
      if (!bestV || sadv < bestS) begin bestV = 1'b1; bestS = sadv; bestA = 8'hC0 + i; end
    end
    idle(10);
    checkOutput("wide2_pulses", m2Cyc.size(), 2);
    while (expC.size() > 0)
      checkPulse2("wide2", expC.pop_front(), expS.pop_front(), expA.pop_front());
    checkOutput("wide2_best_sad", int'(b2.best_sad), bestS);
    checkOutput("wide2_best_addr", int'(b2.best_addr), bestA);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/sad_block_engine.md
# sad_block_engine

Parametrised, pipelined sum-of-absolute-differences engine for block-matching motion estimation. Each valid beat carries one row of COLS current-block pixels and one row of candidate-block pixels. ROWS beats form one candidate. The engine emits one SAD per candidate, tagged with its search address, and tracks the best (minimum) candidate of the current search. It sits between the search-window shift register / address generator and the motion-vector output stage.

## Interface
- PIX_W, 8, pixel width in bits
- COLS, 4, pixels per row beat; power of two, ≥2
- ROWS, 4, row beats per candidate block; ≥1
- ADDR_W, 8, width of candidate address tag
- Derived: SAD_W = PIX_W + clog2(COLS*ROWS) (12 at defaults); TREE_LAT = clog2(COLS)

Ports:
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- search_start  in  1  pulse: begin a new search, clear best, flush pipeline
- in_valid  in  1  row beat valid
- in_first  in  1  qualifies in_valid; beat is row 0 of a new candidate
- cur_row  in  COLS*PIX_W  current-block row; pixel 0 in MSBs
- can_row  in  COLS*PIX_W  candidate-block row; same packing
- can_addr  in  ADDR_W  candidate address; sampled only on in_valid&&in_first
- sad_valid  out  1  one-cycle pulse: sad/sad_addr valid
- sad  out  SAD_W  SAD of completed candidate
- sad_addr  out  ADDR_W  address tag of that candidate
- best_valid  out  1  at least one SAD accepted since last search_start/reset
- best_sad  out  SAD_W  minimum SAD this search
- best_addr  out  ADDR_W  address of best_sad

## Operation
- Stage A (registered): per pixel |cur−can| as unsigned PIX_W difference (larger minus smaller); never wraps.
- Stage T: registered binary adder tree, TREE_LAT levels. Each level widens by 1 bit; row sum is PIX_W+TREE_LAT bits.
- Stage C (accumulator): a row counter runs 0..ROWS-1.
  - A beat with in_first loads acc with the row sum and sets count=1.
  - A non-first beat adds to acc and increments count.
  - When count reaches ROWS, the SAD is registered to sad/sad_addr and sad_valid pulses.
- A beat without in_first while no candidate is open (count=0) is discarded.
- in_first arriving mid-candidate abandons the partial candidate without output and restarts.
- Gaps (in_valid=0) between beats of one candidate are allowed. No back-pressure.
- Address tag and first/valid flags travel in side registers matched to the pipeline depth.
- Best tracker, on sad_valid:
  - If !best_valid or sad < best_sad (strict), load best_sad/best_addr and set best_valid.
  - Ties keep the earlier address.
- search_start:
  - Clears all pipeline valid bits and the row counter. In-flight rows and candidates are dropped.
  - Sets best_valid=0, best_sad=all-ones, best_addr=0.
  - A beat presented in the same cycle as search_start is accepted as belonging to the new search.
- rst: same effect as search_start. In addition sad=0, sad_addr=0, sad_valid=0.

## Timing
- Latency from the accepting edge of the last row beat (row ROWS-1) to sad_valid high: TREE_LAT+2 cycles (4 at defaults).
- best_* update one cycle after sad_valid, i.e. registered from sad/sad_addr.
- Throughput: one row beat per cycle. With back-to-back candidates, sad_valid pulses every ROWS cycles.
- Reset values: sad_valid=0, sad=0, sad_addr=0, best_valid=0, best_sad='1, best_addr=0.
- rst/search_start asserted mid-operation take effect at that edge. No sad_valid pulse occurs for any beat accepted before it.
- Outputs hold their last values between pulses.

## Structure
- Shared package me_pkg:
  - clog2 function
  - SAD_W/row-sum width helper functions
  - default PIX_W/COLS/ROWS constants shared with the address generator
- Sub-module sad_adder_tree: parametrised (N inputs, IN_W), registered per level, valid side-band, latency clog2(N).
- Top holds the abs-diff stage, accumulator/row counter, tag pipeline and best tracker.

## Test plan
- Defaults, one candidate: all cur=10, all can=13 (4 rows) -> sad=48, sad_addr=tag, sad_valid 4 cycles after row 3; best_sad=48 next cycle.
- Extremes: cur=0x00, can=0xFF for all 16 pixels -> sad=4080 (fits 12 bits); then swap cur/can -> again 4080.
- Three back-to-back candidates with tags 0x21/0x35/0x47, SADs 100/60/60 -> three pulses 4 cycles apart; final best_sad=60, best_addr=0x35 (tie keeps earlier).
- in_first after 2 rows of tag 0x10, then 4 rows of tag 0x11 -> exactly one pulse, sad_addr=0x11; gaps of 3 idle cycles inside a candidate do not change the sum.
- search_start while a candidate is 1 cycle from completion -> no pulse; best_valid=0, best_sad=0xFFF; next candidate SAD=7 -> best_sad=7.
- Parameter sweep COLS=8, ROWS=2, PIX_W=10: random data against a scoreboard model, latency 5 cycles, with rst asserted mid-stream.
